// File: rtl/sdram_cmd_decode_if.sv
// Byte-stream, trigger and write-FIFO drain signals between the command decoder
// and its neighbours (stream source as master side, decoder as slave side).
interface sdram_cmd_decode_if #(
  parameter int CNT_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             wr_trig;
  logic             rd_trig;
  logic             wfifo_rd_en;
  logic [7:0]       wfifo_rd_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_cnt;
  logic             cmd_err;
  logic             busy;

  modport slave (
    input  rx_data, rx_valid, wfifo_rd_en,
    output wr_trig, rd_trig, wfifo_rd_data, fifo_empty, fifo_full, fifo_cnt,
           cmd_err, busy
  );

  modport master (
    output rx_data, rx_valid, wfifo_rd_en,
    input  wr_trig, rd_trig, wfifo_rd_data, fifo_empty, fifo_full, fifo_cnt,
           cmd_err, busy
  );
endinterface

// File: rtl/sdram_cmd_decode.sv
// Parses a byte stream into SDRAM write/read triggers and buffers write payload
// in a small FIFO drained by the controller's write stage.
module sdram_cmd_decode #(
  parameter int         WR_BURST_LEN = 4,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CNT_W        = 5,
  parameter logic [7:0] CMD_WR       = 8'h55,
  parameter logic [7:0] CMD_RD       = 8'hAA
) (
  input  logic              sclk,
  input  logic              reset,
  sdram_cmd_decode_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BC_W  = (WR_BURST_LEN > 1) ? $clog2(WR_BURST_LEN) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WR_BURST_LEN - 1);

  typedef enum logic {S_IDLE, S_WDATA} state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              drop_q, drop_d;
  logic              wr_trig_q, wr_trig_d;
  logic              rd_trig_q, rd_trig_d;
  logic              cmd_err_q, cmd_err_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [FIFO_DEPTH];
  logic              push, pop, full;

  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    drop_d     = drop_q;
    wr_trig_d  = 1'b0;
    rd_trig_d  = 1'b0;
    cmd_err_d  = 1'b0;
    push       = 1'b0;
    pop        = bus.wfifo_rd_en && (cnt_q != '0);
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WR) begin
            state_d    = S_WDATA;
            byte_cnt_d = '0;
            drop_d     = 1'b0;
          end else if (bus.rx_data == CMD_RD) begin
            rd_trig_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (bus.rx_valid) begin
          // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
            drop_d    = 1'b1;
          end
          // Framing advances even on dropped bytes; a lossy burst never triggers.
          if (byte_cnt_q == BC_LAST) begin
            state_d    = S_IDLE;
            byte_cnt_d = '0;
            wr_trig_d  = !drop_d;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      drop_q     <= 1'b0;
      wr_trig_q  <= 1'b0;
      rd_trig_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      drop_q     <= drop_d;
      wr_trig_q  <= wr_trig_d;
      rd_trig_q  <= rd_trig_d;
      cmd_err_q  <= cmd_err_d;
      cnt_q      <= cnt_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q    <= rptr_q + PTR_W'(1);
        rd_data_q <= mem[rptr_q];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge sclk) begin
    if (push) mem[wptr_q] <= bus.rx_data;
  end

  assign bus.wr_trig       = wr_trig_q;
  assign bus.rd_trig       = rd_trig_q;
  assign bus.cmd_err       = cmd_err_q;
  assign bus.wfifo_rd_data = rd_data_q;
  assign bus.fifo_cnt      = cnt_q;
  assign bus.fifo_empty    = (cnt_q == '0);
  assign bus.fifo_full     = full;
  assign bus.busy          = (state_q == S_WDATA);
endmodule

// File: tb/tb_sdram_cmd_decode.sv
// Directed bench for sdram_cmd_decode: a queue scoreboard holds the bytes the
// FIFO should contain; pulses and counts are compared after every edge.
module tb_sdram_cmd_decode;
  logic sclk = 1'b0;
  logic reset;
  always #5 sclk = ~sclk;

  sdram_cmd_decode_if #(.CNT_W(5)) bus ();

  sdram_cmd_decode #(
    .WR_BURST_LEN(4), .FIFO_DEPTH(16), .CNT_W(5), .CMD_WR(8'h55), .CMD_RD(8'hAA)
  ) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int n_err = 0;

  // Scoreboard and reference state.
  logic [7:0] sb[$];
  logic [7:0] last_data;
  bit         m_wd;
  int         m_bc;
  bit         m_drop;

  always @(negedge sclk) begin
    if (bus.wr_trig) n_wr++;
    if (bus.cmd_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input bit ew, input bit er, input bit ee);
    check({tag, ".wr_trig"}, 32'(bus.wr_trig), 32'(ew));
    check({tag, ".rd_trig"}, 32'(bus.rd_trig), 32'(er));
    check({tag, ".cmd_err"}, 32'(bus.cmd_err), 32'(ee));
    check({tag, ".fifo_cnt"}, 32'(bus.fifo_cnt), 32'(sb.size()));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_wd));
  endtask

  // Reference update for one accepted stream byte; 'popping' marks a same-edge pop.
  task automatic model_byte(input logic [7:0] b, input bit popping,
                            output bit ew, output bit er, output bit ee);
    ew = 0; er = 0; ee = 0;
    if (!m_wd) begin
      if (b == 8'h55) begin m_wd = 1; m_bc = 0; m_drop = 0; end
      else if (b == 8'hAA) er = 1;
      else ee = 1;
    end else begin
      if (sb.size() < 16 || popping) sb.push_back(b);
      else begin m_drop = 1; ee = 1; end
      if (m_bc == 3) begin m_wd = 0; m_bc = 0; ew = !m_drop; end
      else m_bc++;
    end
  endtask

  task automatic do_reset();
    @(negedge sclk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.wfifo_rd_en = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    reset = 1'b0;
    sb.delete();
    m_wd = 0; m_bc = 0; m_drop = 0;
    last_data = 8'h00;
    check_pulses("reset", 0, 0, 0);
    check("reset.empty", 32'(bus.fifo_empty), 32'd1);
    check("reset.full", 32'(bus.fifo_full), 32'd0);
    check("reset.rd_data", 32'(bus.wfifo_rd_data), 32'h00);
  endtask

  task automatic send(input logic [7:0] b);
    bit ew, er, ee;
    @(negedge sclk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge sclk);
    #1;
    bus.rx_valid = 1'b0;
    model_byte(b, 1'b0, ew, er, ee);
    check_pulses($sformatf("send_%02h", b), ew, er, ee);
  endtask

  task automatic idle();
    @(negedge sclk);
    @(posedge sclk);
    #1;
    check_pulses("idle", 0, 0, 0);
  endtask

  task automatic pop_one();
    logic [7:0] exp;
    @(negedge sclk);
    bus.wfifo_rd_en = 1'b1;
    @(posedge sclk);
    #1;
    bus.wfifo_rd_en = 1'b0;
    if (sb.size() > 0) last_data = sb.pop_front();
    exp = last_data;
    check("pop.data", 32'(bus.wfifo_rd_data), 32'(exp));
    check("pop.cnt", 32'(bus.fifo_cnt), 32'(sb.size()));
    check("pop.empty", 32'(bus.fifo_empty), 32'(sb.size() == 0));
  endtask

  // Push a stream byte and pop on the same edge.
  task automatic push_pop(input logic [7:0] b);
    bit ew, er, ee;
    @(negedge sclk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    bus.wfifo_rd_en = 1'b1;
    @(posedge sclk);
    #1;
    bus.rx_valid = 1'b0;
    bus.wfifo_rd_en = 1'b0;
    if (sb.size() > 0) begin
      last_data = sb.pop_front();
      model_byte(b, 1'b1, ew, er, ee);
    end else begin
      model_byte(b, 1'b0, ew, er, ee);
    end
    check("pushpop.data", 32'(bus.wfifo_rd_data), 32'(last_data));
    check_pulses("pushpop", ew, er, ee);
  endtask

  int wr0, err0;

  initial begin
    reset = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.wfifo_rd_en = 1'b0;
    last_data = 8'h00;

    do_reset();

    // Basic write packet, then drain.
    send(8'h55); send(8'h11); send(8'h22); send(8'h33);
    check("wpkt.cnt3", 32'(bus.fifo_cnt), 32'd3);
    send(8'h44);
    check("wpkt.wr_trig", 32'(bus.wr_trig), 32'd1);
    check("wpkt.cnt4", 32'(bus.fifo_cnt), 32'd4);
    idle();
    pop_one(); check("wpkt.d0", 32'(bus.wfifo_rd_data), 32'h11);
    pop_one(); pop_one(); pop_one();
    check("wpkt.d3", 32'(bus.wfifo_rd_data), 32'h44);
    check("wpkt.empty", 32'(bus.fifo_empty), 32'd1);

    // Read command and bad opcode.
    send(8'hAA);
    check("rd.pulse", 32'(bus.rd_trig), 32'd1);
    send(8'h07);
    check("err.pulse", 32'(bus.cmd_err), 32'd1);
    check("err.rd_off", 32'(bus.rd_trig), 32'd0);
    idle();

    // Overflow: five packets, no pops.
    wr0 = n_wr; err0 = n_err;
    for (int p = 0; p < 5; p++) begin
      send(8'h55);
      for (int k = 0; k < 4; k++) send(8'(8'h80 + p * 4 + k));
      if (p == 3) check("ovf.full", 32'(bus.fifo_full), 32'd1);
    end
    idle();
    check("ovf.wr_count", 32'(n_wr - wr0), 32'd4);
    check("ovf.err_count", 32'(n_err - err0), 32'd4);
    for (int k = 0; k < 16; k++) pop_one();
    check("ovf.last", 32'(bus.wfifo_rd_data), 32'h8F);

    // Concurrent push/pop at count 3, then pop on empty.
    send(8'h55); send(8'hA1); send(8'hA2); send(8'hA3);
    push_pop(8'hA4);
    check("conc.head", 32'(bus.wfifo_rd_data), 32'hA1);
    check("conc.cnt", 32'(bus.fifo_cnt), 32'd3);
    check("conc.wr_trig", 32'(bus.wr_trig), 32'd1);
    pop_one(); pop_one(); pop_one();
    check("conc.tail", 32'(bus.wfifo_rd_data), 32'hA4);
    pop_one();
    check("empty_pop.hold", 32'(bus.wfifo_rd_data), 32'hA4);
    check("empty_pop.cnt", 32'(bus.fifo_cnt), 32'd0);

    // Mid-packet reset, then a clean packet.
    wr0 = n_wr;
    send(8'h55); send(8'hAA); send(8'hBB);
    do_reset();
    idle();
    check("mid_rst.no_wr", 32'(n_wr - wr0), 32'd0);
    send(8'h55); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("post_rst.wr_trig", 32'(bus.wr_trig), 32'd1);
    idle();
    for (int k = 0; k < 4; k++) pop_one();
    check("post_rst.last", 32'(bus.wfifo_rd_data), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
